// File: rtl/filtro_fir_secuenciador.sv
// FIR sequencer: keeps the sample delay line, steps an external combinational MAC
// one tap per cycle, then rounds and saturates the accumulator to an N-bit sample.
module filtro_fir_secuenciador #(
  parameter int N    = 25,
  parameter int FRAC = 16,
  parameter int TAPS = 5,
  parameter int AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    sample_in,
  input  logic            sample_valid,
  output logic            ready,
  output logic [AW-1:0]   coef_addr,
  input  logic [N-1:0]    coef_in,
  output logic [N-1:0]    mult_a,
  output logic [N-1:0]    mult_b,
  output logic [2*N-1:0]  acc_fb,
  input  logic [2*N-1:0]  mac_result,
  output logic [N-1:0]    y_out,
  output logic            y_valid
);

  // state  | meaning
  // S_IDLE | ready, waiting for a sample; acceptance shifts the delay line
  // S_MAC  | one tap per cycle, acc <= mac_result, idx 0..TAPS-1
  // S_SAT  | round, saturate and register the output sample
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

  localparam logic signed [2*N:0] C_MAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] C_MIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};
  localparam logic [2*N:0]        C_HALF = (2*N+1)'(1) << (FRAC-1);

  state_t              r_state;
  state_t              w_next;
  logic [N-1:0]        r_delay [TAPS];
  logic [2*N-1:0]      r_acc;
  logic [AW-1:0]       r_idx;
  logic [N-1:0]        r_y;
  logic                r_y_valid;

  logic [2*N:0]        w_round;
  logic signed [2*N:0] w_shift;
  logic [N-1:0]        w_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (sample_valid) w_next = S_MAC;
      S_MAC:   if (r_idx == AW'(TAPS-1)) w_next = S_SAT;
      S_SAT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    coef_addr = '0;
    mult_a    = '0;
    mult_b    = '0;
    acc_fb    = '0;
    case (r_state)
      S_IDLE: ready = 1'b1;
      S_MAC: begin
        coef_addr = r_idx;
        mult_a    = r_delay[r_idx];
        mult_b    = coef_in;
        acc_fb    = r_acc;
      end
      default: ;
    endcase
  end

  // Round half up in one extra bit so the bias cannot overflow the accumulator range.
  always_comb begin
    w_round = {r_acc[2*N-1], r_acc} + C_HALF;
    w_shift = $signed(w_round) >>> FRAC;
    if (w_shift > C_MAX)      w_sat = C_MAX[N-1:0];
    else if (w_shift < C_MIN) w_sat = C_MIN[N-1:0];
    else                      w_sat = w_shift[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_delay[i] <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= (r_state == S_SAT);
      case (r_state)
        S_IDLE: if (sample_valid) begin
          for (int i = TAPS-1; i > 0; i--) r_delay[i] <= r_delay[i-1];
          r_delay[0] <= sample_in;
          r_acc      <= '0;
          r_idx      <= '0;
        end
        S_MAC: begin
          r_acc <= mac_result;
          r_idx <= r_idx + AW'(1);
        end
        S_SAT: r_y <= w_sat;
        default: ;
      endcase
    end
  end

  assign y_out   = r_y;
  assign y_valid = r_y_valid;

endmodule
